// File: rtl/apb_mon_pkg.sv
// Shared types and constants for the APB transaction monitor.
package apb_mon_pkg;

    // Bus phase tracked by the monitor FSM.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESYNC
    } mon_state_t;

    // Violation bit positions within viol_code.
    localparam int VIOL_NO_SETUP  = 0;
    localparam int VIOL_NO_ACCESS = 1;
    localparam int VIOL_UNSTABLE  = 2;
    localparam int VIOL_TIMEOUT   = 3;
    localparam int VIOL_W         = 4;

    // Packed capture word, LSB first: write, slverr, waits, strb, data, addr.
    // The fixed single-bit fields sit at the bottom; the rest follow by width.
    localparam int CAP_OFF_WRITE  = 0;
    localparam int CAP_OFF_SLVERR = 1;
    localparam int CAP_OFF_WAITS  = 2;

    function automatic int cap_off_strb(input int wait_w);
        return CAP_OFF_WAITS + wait_w;
    endfunction

    function automatic int cap_off_data(input int wait_w, input int strb_w);
        return cap_off_strb(wait_w) + strb_w;
    endfunction

    function automatic int cap_off_addr(input int wait_w, input int strb_w, input int data_w);
        return cap_off_data(wait_w, strb_w) + data_w;
    endfunction

    function automatic int cap_width(input int wait_w, input int strb_w, input int data_w,
                                     input int addr_w);
        return cap_off_addr(wait_w, strb_w, data_w) + addr_w;
    endfunction

endpackage

// File: rtl/apb_mon_fifo.sv
// Synchronous FIFO for captured transfers; flush has priority, a push into a
// full FIFO is accepted when a pop happens on the same edge.
module apb_mon_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    // Head is forced to zero while empty so idle outputs read as zero.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write; data is only ever read behind a valid pointer.
    // NOTE: the array has no reset -- occupancy is tracked by count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: registers take non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_txn_monitor.sv
// Passive APB3/APB4 tap: protocol checks, capture FIFO and saturating statistics.
module apb_txn_monitor
    import apb_mon_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 8,
    parameter  int MAX_WAIT   = 16,
    parameter  int CNT_WIDTH  = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int WAIT_W     = $clog2(MAX_WAIT + 1)
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSELx,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  clr_i,
    input  logic                  cap_ready,
    output logic                  cap_valid,
    output logic [ADDR_WIDTH-1:0] cap_addr,
    output logic [DATA_WIDTH-1:0] cap_data,
    output logic                  cap_write,
    output logic [STRB_WIDTH-1:0] cap_strb,
    output logic                  cap_slverr,
    output logic [WAIT_W-1:0]     cap_waits,
    output logic                  cap_overflow,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  slverr_cnt,
    output logic [CNT_WIDTH-1:0]  viol_cnt,
    output logic                  viol_o,
    output logic [VIOL_W-1:0]     viol_code
);

    localparam int OFF_STRB = cap_off_strb(WAIT_W);
    localparam int OFF_DATA = cap_off_data(WAIT_W, STRB_WIDTH);
    localparam int OFF_ADDR = cap_off_addr(WAIT_W, STRB_WIDTH, DATA_WIDTH);
    localparam int CAP_W    = cap_width(WAIT_W, STRB_WIDTH, DATA_WIDTH, ADDR_WIDTH);

    mon_state_t            state;
    mon_state_t            state_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [STRB_WIDTH-1:0] lat_strb;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [WAIT_W-1:0]     wait_nxt;
    logic                  latch_en;
    logic                  push;
    logic [VIOL_W-1:0]     viol_vec;
    logic                  in_access;
    logic                  unstable;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CAP_W-1:0]      cap_word_in;
    logic [CAP_W-1:0]      cap_word_out;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign in_access = PSELx && PENABLE;
    assign unstable  = (PADDR != lat_addr) || (PWRITE != lat_write) || (PSTRB != lat_strb) ||
                       (lat_write && (PWDATA != lat_wdata));

    // Phase decode of the current sample: next state, violation, completion.
    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves it unassigned (no latch).
        state_nxt = state;
        latch_en  = 1'b0;
        wait_nxt  = wait_cnt;
        viol_vec  = '0;
        push      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (PSELx && !PENABLE) begin
                    state_nxt = ST_SETUP;
                    latch_en  = 1'b1;
                end else if (in_access) begin
                    viol_vec[VIOL_NO_SETUP] = 1'b1;
                    state_nxt               = ST_RESYNC;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP, ST_ACCESS: begin
                if (!in_access) begin
                    if (state == ST_SETUP) viol_vec[VIOL_NO_ACCESS] = 1'b1;
                    else                   viol_vec[VIOL_UNSTABLE]  = 1'b1;
                    state_nxt = ST_RESYNC;
                end else if (unstable) begin
                    viol_vec[VIOL_UNSTABLE] = 1'b1;
                    state_nxt               = ST_RESYNC;
                end else if (PREADY) begin
                    push      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    viol_vec[VIOL_TIMEOUT] = 1'b1;
                    state_nxt              = ST_RESYNC;
                end else begin
                    wait_nxt  = wait_cnt + WAIT_W'(1);
                    state_nxt = ST_ACCESS;
                end
            end
            ST_RESYNC: begin
                // The first sample with PENABLE low is judged as if in IDLE.
                if (!PENABLE) begin
                    if (PSELx) begin
                        state_nxt = ST_SETUP;
                        latch_en  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // FSM state, setup-phase latches and wait counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            wait_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (latch_en) begin
                lat_addr  <= PADDR;
                lat_write <= PWRITE;
                lat_wdata <= PWDATA;
                lat_strb  <= PSTRB;
                wait_cnt  <= '0;
            end else begin
                wait_cnt <= wait_nxt;
            end
        end
    end

    // Reads capture PRDATA from the completing sample; writes keep the setup data.
    assign cap_word_in = {lat_addr, (lat_write ? lat_wdata : PRDATA), lat_strb, wait_cnt,
                          PSLVERR, lat_write};
    assign pop         = cap_valid && cap_ready;

    apb_mon_fifo #(
        .WIDTH (CAP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (push),
        .wdata (cap_word_in),
        .pop   (pop),
        .flush (clr_i),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (cap_word_out)
    );

    assign cap_valid  = !fifo_empty;
    assign cap_write  = cap_word_out[CAP_OFF_WRITE];
    assign cap_slverr = cap_word_out[CAP_OFF_SLVERR];
    assign cap_waits  = cap_word_out[CAP_OFF_WAITS +: WAIT_W];
    assign cap_strb   = cap_word_out[OFF_STRB +: STRB_WIDTH];
    assign cap_data   = cap_word_out[OFF_DATA +: DATA_WIDTH];
    assign cap_addr   = cap_word_out[OFF_ADDR +: ADDR_WIDTH];

    // Statistics, sticky flags; clear beats any same-cycle update.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            slverr_cnt   <= '0;
            viol_cnt     <= '0;
            viol_code    <= '0;
            cap_overflow <= 1'b0;
        end else if (clr_i) begin
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            slverr_cnt   <= '0;
            viol_cnt     <= '0;
            viol_code    <= '0;
            cap_overflow <= 1'b0;
        end else begin
            if (push) begin
                if (lat_write) wr_cnt <= sat_inc(wr_cnt);
                else           rd_cnt <= sat_inc(rd_cnt);
                if (PSLVERR)   slverr_cnt <= sat_inc(slverr_cnt);
                if (fifo_full && !pop) cap_overflow <= 1'b1;
            end
            if (|viol_vec) begin
                viol_cnt  <= sat_inc(viol_cnt);
                viol_code <= viol_code | viol_vec;
            end
        end
    end

    // One-cycle violation pulse following the detecting edge.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) viol_o <= 1'b0;
        else          viol_o <= |viol_vec;
    end

endmodule

// File: tb/tb_apb_txn_monitor.sv
// Self-checking bench for apb_txn_monitor: directed table, corner sequences,
// then random traffic against a transaction-level model.
module tb_apb_txn_monitor;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 4;
    localparam int MAXW  = 5;
    localparam int CW    = 6;
    localparam int WW    = $clog2(MAXW + 1);
    localparam int CMAX  = (1 << CW) - 1;

    typedef enum int {F_NONE, F_NO_SETUP, F_DROP_EN, F_UNSTABLE, F_TIMEOUT} fault_e;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [SW-1:0] strb;
        int            waits;
        logic          slverr;
        fault_e        fault;
        int            at;
        int            pert;
        int            exp_viol;
        bit            exp_cap;
        int            gap;
    } vec_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          write;
        logic [SW-1:0] strb;
        logic          slverr;
        logic [WW-1:0] waits;
    } cap_t;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          psel, pen, pwrite, pready, pslverr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;
    logic          clr_i, cap_ready;

    logic          cap_valid, cap_write, cap_slverr, cap_overflow, viol_o;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic [SW-1:0] cap_strb;
    logic [WW-1:0] cap_waits;
    logic [CW-1:0] wr_cnt, rd_cnt, slverr_cnt, viol_cnt;
    logic [3:0]    viol_code;

    apb_txn_monitor #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW),
        .CNT_WIDTH  (CW)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .PSELx        (psel),
        .PENABLE      (pen),
        .PWRITE       (pwrite),
        .PREADY       (pready),
        .PSLVERR      (pslverr),
        .PADDR        (paddr),
        .PWDATA       (pwdata),
        .PRDATA       (prdata),
        .PSTRB        (pstrb),
        .clr_i        (clr_i),
        .cap_ready    (cap_ready),
        .cap_valid    (cap_valid),
        .cap_addr     (cap_addr),
        .cap_data     (cap_data),
        .cap_write    (cap_write),
        .cap_strb     (cap_strb),
        .cap_slverr   (cap_slverr),
        .cap_waits    (cap_waits),
        .cap_overflow (cap_overflow),
        .wr_cnt       (wr_cnt),
        .rd_cnt       (rd_cnt),
        .slverr_cnt   (slverr_cnt),
        .viol_cnt     (viol_cnt),
        .viol_o       (viol_o),
        .viol_code    (viol_code)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: expected FIFO contents and statistics.
    cap_t       mq[$];
    int         m_wr, m_rd, m_sl, m_vc;
    logic [3:0] m_code;
    bit         m_ovf;
    bit         rand_ready;
    bit         ready_on_complete;
    bit         clr_on_complete;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr = 0; m_rd = 0; m_sl = 0; m_vc = 0;
        m_code = 4'h0;
        m_ovf = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, cap_valid, 0);
        check({tag, "_head"}, {cap_addr, cap_data, cap_write, cap_strb, cap_slverr, cap_waits}, 0);
        check({tag, "_ovf"}, cap_overflow, 0);
        check({tag, "_cnts"}, {wr_cnt, rd_cnt, slverr_cnt, viol_cnt}, 0);
        check({tag, "_viol"}, {viol_o, viol_code}, 0);
    endtask

    // One clock: apply current inputs, advance the model, compare everything.
    task automatic step(input bit push, input cap_t ent, input int vbit, input bit clr);
        bit do_pop;
        if (rand_ready) cap_ready = ($urandom_range(0, 3) != 0);
        do_pop = (mq.size() > 0) && cap_ready;
        clr_i = clr;
        @(posedge PCLK);
        #1;
        clr_i = 1'b0;
        if (clr) begin
            mq.delete();
            m_wr = 0; m_rd = 0; m_sl = 0; m_vc = 0;
            m_code = 4'h0;
            m_ovf = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(ent);
                else                   m_ovf = 1'b1;
                if (ent.write) m_wr = sat(m_wr);
                else           m_rd = sat(m_rd);
                if (ent.slverr) m_sl = sat(m_sl);
            end
            if (vbit >= 0) begin
                m_code[vbit] = 1'b1;
                m_vc = sat(m_vc);
            end
        end
        check("viol_o", viol_o, (vbit >= 0) ? 1 : 0);
        check("viol_code", viol_code, m_code);
        check("viol_cnt", viol_cnt, m_vc);
        check("wr_cnt", wr_cnt, m_wr);
        check("rd_cnt", rd_cnt, m_rd);
        check("slverr_cnt", slverr_cnt, m_sl);
        check("cap_overflow", cap_overflow, m_ovf);
        check("cap_valid", cap_valid, (mq.size() > 0) ? 1 : 0);
        if (mq.size() > 0)
            check("cap_head", {cap_addr, cap_data, cap_write, cap_strb, cap_slverr, cap_waits}, mq[0]);
    endtask

    task automatic idle(input int n);
        cap_t z;
        z = '0;
        for (int i = 0; i < n; i++) begin
            psel = 1'b0; pen = 1'b0; pwrite = $urandom_range(0, 1);
            pready = $urandom_range(0, 1); paddr = $urandom;
            step(1'b0, z, -1, 1'b0);
        end
    endtask

    // Drive one transfer as described by v; expected effects come from v.exp_*.
    task automatic xfer(input vec_t v);
        cap_t ent;
        int   n;
        bit   last;
        ent.addr   = v.addr;
        ent.data   = v.write ? v.wdata : v.rdata;
        ent.write  = v.write;
        ent.strb   = v.strb;
        ent.slverr = v.slverr;
        ent.waits  = WW'(v.waits);
        psel = 1'b1; paddr = v.addr; pwrite = v.write; pstrb = v.strb;
        pwdata = v.write ? v.wdata : DW'($urandom);
        pready = $urandom_range(0, 1); pslverr = 1'b0; prdata = $urandom;
        if (v.fault == F_NO_SETUP) begin
            pen = 1'b1;
            step(1'b0, ent, v.exp_viol, 1'b0);
            return;
        end
        pen = 1'b0;
        step(1'b0, ent, -1, 1'b0);
        n = (v.fault == F_TIMEOUT) ? MAXW + 1 : ((v.fault == F_NONE) ? v.waits + 1 : v.at + 1);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            pen = 1'b1; pready = 1'b0; prdata = $urandom; pslverr = $urandom_range(0, 1);
            if (!v.write) pwdata = $urandom;
            if (last) begin
                case (v.fault)
                    F_NONE: begin
                        pready = 1'b1; prdata = v.rdata; pslverr = v.slverr;
                        if (ready_on_complete) cap_ready = 1'b1;
                    end
                    F_DROP_EN: begin
                        pen = 1'b0; pready = $urandom_range(0, 1);
                    end
                    F_UNSTABLE: begin
                        pready = $urandom_range(0, 1);
                        case (v.pert)
                            1:       pstrb  = v.strb ^ SW'(1);
                            2:       pwrite = ~v.write;
                            3:       if (v.write) pwdata = v.wdata ^ DW'(1);
                                     else         paddr  = v.addr ^ AW'(4);
                            default: paddr  = v.addr ^ AW'(4);
                        endcase
                    end
                    default: ;
                endcase
            end
            step(last && v.exp_cap, ent, last ? v.exp_viol : -1, last && clr_on_complete);
        end
        if (ready_on_complete) cap_ready = 1'b0;
        paddr = v.addr; pwrite = v.write; pstrb = v.strb;
    endtask

    function automatic vec_t mk(input logic [AW-1:0] addr, input logic write,
                                input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                input logic [SW-1:0] strb, input int waits, input logic slverr,
                                input fault_e fault, input int at, input int pert,
                                input int exp_viol, input bit exp_cap, input int gap);
        vec_t v;
        v.addr = addr; v.write = write; v.wdata = wdata; v.rdata = rdata; v.strb = strb;
        v.waits = waits; v.slverr = slverr; v.fault = fault; v.at = at; v.pert = pert;
        v.exp_viol = exp_viol; v.exp_cap = exp_cap; v.gap = gap;
        return v;
    endfunction

    // Random transfer; its expected outcome follows directly from the protocol rules.
    function automatic vec_t rand_vec();
        vec_t v;
        int   r;
        r = $urandom_range(0, 9);
        v = mk($urandom, 1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom),
               $urandom_range(0, MAXW), 1'($urandom_range(0, 1)), F_NONE, 0,
               $urandom_range(0, 3), -1, 1'b1, $urandom_range(0, 2));
        case (r)
            0: v.fault = F_NO_SETUP;
            1: begin v.fault = F_DROP_EN;  v.at = $urandom_range(0, 3); end
            2: begin v.fault = F_UNSTABLE; v.at = $urandom_range(0, MAXW); end
            3: v.fault = F_TIMEOUT;
            default: v.fault = F_NONE;
        endcase
        case (v.fault)
            F_NO_SETUP: v.exp_viol = 0;
            F_DROP_EN:  v.exp_viol = (v.at == 0) ? 1 : 2;
            F_UNSTABLE: v.exp_viol = 2;
            F_TIMEOUT:  v.exp_viol = 3;
            default:    v.exp_viol = -1;
        endcase
        v.exp_cap = (v.fault == F_NONE);
        if (!v.exp_cap && v.gap == 0) v.gap = 1;
        return v;
    endfunction

    task automatic drain(output int n);
        n = 0;
        cap_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && cap_valid; i++) begin
            n++;
            idle(1);
        end
    endtask

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   n;
        vec_t v;
        tbl[0] = mk(32'h10, 1, 32'hDEADBEEF, 32'h0, 4'hF, 0, 0, F_NONE, 0, 0, -1, 1, 0);
        tbl[1] = mk(32'h20, 0, 32'h0, 32'h1234, 4'h0, 3, 1, F_NONE, 0, 0, -1, 1, 1);
        tbl[2] = mk(32'h30, 1, 32'h55, 32'h0, 4'h3, 0, 0, F_NO_SETUP, 0, 0, 0, 0, 1);
        tbl[3] = mk(32'h40, 0, 32'h0, 32'h99, 4'h0, 0, 0, F_UNSTABLE, 2, 0, 2, 0, 1);
        tbl[4] = mk(32'h50, 1, 32'hA5A5, 32'h0, 4'hF, 0, 0, F_TIMEOUT, 0, 0, 3, 0, 1);
        tbl[5] = mk(32'h44, 1, 32'hCAFE, 32'h0, 4'hC, 1, 0, F_NONE, 0, 0, -1, 1, 1);
        tbl[6] = mk(32'h60, 1, 32'h1, 32'h0, 4'h1, 0, 0, F_DROP_EN, 0, 0, 1, 0, 1);
        tbl[7] = mk(32'h64, 0, 32'h0, 32'h2, 4'h0, 0, 0, F_DROP_EN, 2, 0, 2, 0, 1);
        tbl[8] = mk(32'h68, 1, 32'h77, 32'h0, 4'hF, 0, 0, F_UNSTABLE, 1, 3, 2, 0, 1);
        tbl[9] = mk(32'h6C, 0, 32'h0, 32'hBEEF, 4'h0, MAXW, 0, F_NONE, 0, 0, -1, 1, 1);

        PRESETn = 1'b0;
        psel = 0; pen = 0; pwrite = 0; pready = 0; pslverr = 0;
        paddr = '0; pwdata = '0; prdata = '0; pstrb = '0;
        clr_i = 0; cap_ready = 0;
        rand_ready = 0; ready_on_complete = 0; clr_on_complete = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        idle(1);

        // Directed vectors with the consumer always ready.
        cap_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            xfer(tbl[i]);
            idle(tbl[i].gap);
        end
        idle(2);

        // Overflow: DEPTH+2 writes with nobody consuming.
        idle(1);
        step(1'b0, '0, -1, 1'b1);
        cap_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            xfer(mk(32'h100 + 4 * i, 1, 32'h1000 + i, 32'h0, 4'hF, i % 2, 0, F_NONE, 0, 0, -1, 1, 0));
            idle(1);
        end
        check("ovf_flag", cap_overflow, 1);
        check("ovf_wr_cnt", wr_cnt, DEPTH + 2);
        check("ovf_head_addr", cap_addr, 32'h100);
        drain(n);
        check("ovf_drained", n, DEPTH);

        // Full FIFO with a pop on the completing edge keeps the new entry.
        step(1'b0, '0, -1, 1'b1);
        cap_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            xfer(mk(32'h200 + 4 * i, 0, 32'h0, 32'h2000 + i, 4'h0, 0, 0, F_NONE, 0, 0, -1, 1, 0));
        end
        ready_on_complete = 1'b1;
        xfer(mk(32'h2F0, 1, 32'hF00D, 32'h0, 4'h5, 2, 1, F_NONE, 0, 0, -1, 1, 0));
        ready_on_complete = 1'b0;
        check("fullpop_ovf", cap_overflow, 0);
        idle(1);
        drain(n);
        check("fullpop_occupancy", n, DEPTH);

        // Clear on the same edge as a completion.
        cap_ready = 1'b0;
        xfer(mk(32'h300, 1, 32'h3, 32'h0, 4'hF, 0, 0, F_NONE, 0, 0, -1, 1, 1));
        clr_on_complete = 1'b1;
        xfer(mk(32'h304, 0, 32'h0, 32'h4, 4'h0, 1, 1, F_NONE, 0, 0, -1, 1, 1));
        clr_on_complete = 1'b0;
        check("clr_valid", cap_valid, 0);
        check("clr_cnts", {wr_cnt, rd_cnt, slverr_cnt}, 0);
        idle(1);
        xfer(mk(32'h308, 1, 32'h8, 32'h0, 4'hF, 0, 0, F_NONE, 0, 0, -1, 1, 1));
        idle(1);

        // Reset asserted while a transfer sits in ACCESS.
        xfer(mk(32'h400, 0, 32'h0, 32'h44, 4'h0, 0, 1, F_DROP_EN, 2, 0, 2, 0, 1));
        idle(1);
        psel = 1; pen = 0; paddr = 32'h500; pwrite = 1; pwdata = 32'h5; pstrb = 4'hF;
        step(1'b0, '0, -1, 1'b0);
        pen = 1; pready = 0;
        step(1'b0, '0, -1, 1'b0);
        step(1'b0, '0, -1, 1'b0);
        #2 PRESETn = 1'b0;
        #1;
        check_all_zero("midreset");
        psel = 0; pen = 0;
        model_reset();
        @(negedge PCLK);
        PRESETn = 1'b1;
        idle(1);
        xfer(mk(32'h504, 0, 32'h0, 32'h5A5A, 4'h0, 2, 0, F_NONE, 0, 0, -1, 1, 1));
        check("after_reset_cap", {cap_valid, cap_addr, cap_data}, {1'b1, 32'h504, 32'h5A5A});
        idle(1);

        // Random traffic with a randomly stalling consumer; counters reach saturation.
        rand_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            v = rand_vec();
            xfer(v);
            idle(v.gap);
        end
        rand_ready = 1'b0;
        drain(n);
        check("final_empty", cap_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
